// File: rtl/ptw_axi_reader.sv
// Page-table-walk read responder: one pending slot per TLB, round-robin arbitration, one 64-bit AXI4 read per PTE.
// A legal request pulse seen in IDLE goes straight to AR, so the round trip is pulse -> AR -> R -> RESP.
module ptw_axi_reader #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int I_ID       = 0,
    parameter int D_ID       = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
    output logic                  I_RESP_VALID,
    output logic [DATA_WIDTH-1:0] I_RESP_DATA,
    input  logic                  D_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
    output logic                  D_RESP_VALID,
    output logic [DATA_WIDTH-1:0] D_RESP_DATA,
    output logic                  RESP_ERR,
    output logic                  PROTO_ERR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST
);
    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                state, state_nxt;
    logic                  i_vld, d_vld;
    logic [ADDR_WIDTH-1:0] i_addr, d_addr, addr_q;
    logic [ID_WIDTH-1:0]   arid_q;
    logic                  cur_d, ptr_d, err_q, proto_q;
    logic [DATA_WIDTH-1:0] i_data, d_data, rdata_ok;
    logic                  i_busy, d_busy, i_ok, d_ok, i_cand, d_cand;
    logic                  grant_d, start, r_fire;
    logic                  unused_ok;

    assign unused_ok = ^{RID, RLAST};

    // A requester whose fetch is in flight may not pulse again until its response has gone out.
    assign i_busy  = (state != IDLE) && !cur_d;
    assign d_busy  = (state != IDLE) && cur_d;
    assign i_ok    = I_REQ_VALID && !i_vld && !i_busy;
    assign d_ok    = D_REQ_VALID && !d_vld && !d_busy;
    assign i_cand  = i_vld || i_ok;
    assign d_cand  = d_vld || d_ok;
    assign grant_d = d_cand && (!i_cand || ptr_d);
    assign start   = (state == IDLE) && (i_cand || d_cand);
    assign r_fire  = RVALID && RREADY;
    assign rdata_ok = (RRESP == 2'b00) ? RDATA : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = AR;
            AR:      if (ARVALID && ARREADY) state_nxt = R;
            R:       if (r_fire) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs drop in the reset cycle itself; the interconnect is reset alongside us.
    always_comb begin
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        I_RESP_VALID = 1'b0;
        D_RESP_VALID = 1'b0;
        RESP_ERR     = 1'b0;
        if (!RST) begin
            case (state)
                AR:   ARVALID = 1'b1;
                R:    RREADY  = 1'b1;
                RESP: begin
                    I_RESP_VALID = !cur_d;
                    D_RESP_VALID = cur_d;
                    RESP_ERR     = err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_vld   <= 1'b0;
            d_vld   <= 1'b0;
            i_addr  <= '0;
            d_addr  <= '0;
            addr_q  <= '0;
            arid_q  <= '0;
            cur_d   <= 1'b0;
            ptr_d   <= 1'b0;
            err_q   <= 1'b0;
            proto_q <= 1'b0;
            i_data  <= '0;
            d_data  <= '0;
        end else begin
            if (start && !grant_d) begin
                i_vld <= 1'b0;
            end else if (i_ok) begin
                i_vld  <= 1'b1;
                i_addr <= I_REQ_ADDR;
            end
            if (start && grant_d) begin
                d_vld <= 1'b0;
            end else if (d_ok) begin
                d_vld  <= 1'b1;
                d_addr <= D_REQ_ADDR;
            end
            if (start) begin
                cur_d  <= grant_d;
                arid_q <= grant_d ? ID_WIDTH'(D_ID) : ID_WIDTH'(I_ID);
                if (grant_d) begin
                    addr_q <= d_vld ? d_addr : D_REQ_ADDR;
                end else begin
                    addr_q <= i_vld ? i_addr : I_REQ_ADDR;
                end
                if (i_cand && d_cand) begin
                    ptr_d <= !grant_d;
                end
            end
            if (r_fire) begin
                err_q <= (RRESP != 2'b00);
                if (cur_d) begin
                    d_data <= rdata_ok;
                end else begin
                    i_data <= rdata_ok;
                end
            end
            proto_q <= proto_q || (I_REQ_VALID && !i_ok) || (D_REQ_VALID && !d_ok);
        end
    end

    assign ARADDR      = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign ARID        = arid_q;
    assign ARLEN       = 8'd0;
    assign ARSIZE      = 3'd3;
    assign ARBURST     = 2'b01;
    assign ARCACHE     = 4'b0011;
    assign ARPROT      = 3'b001;
    assign I_RESP_DATA = i_data;
    assign D_RESP_DATA = d_data;
    assign PROTO_ERR   = proto_q;
endmodule
